// File: rtl/acc_byte_serializer_if.sv
// acc_byte_serializer_if
// Bundles the word-input, UART-side and status signals of acc_byte_serializer.
//   in_valid / in_data : one-cycle word strobe and accumulated word (WT bits)
//   ovf_clr            : synchronous clear of the sticky overflow flag
//   tx_busy            : UART transmitter busy
//   tx_start / tx_byte : one-cycle send request and the byte to send
//   busy / overflow    : serializer activity and dropped-word flag
// master = word source / UART / status side, slave = serializer.
interface acc_byte_serializer_if #(
  parameter int W  = 6,
  parameter int Wc = 4
);
  localparam int WT = W * Wc;

  logic          in_valid;
  logic [WT-1:0] in_data;
  logic          ovf_clr;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          busy;
  logic          overflow;

  modport master (
    output in_valid, in_data, ovf_clr, tx_busy,
    input  tx_start, tx_byte, busy, overflow
  );

  modport slave (
    input  in_valid, in_data, ovf_clr, tx_busy,
    output tx_start, tx_byte, busy, overflow
  );
endinterface

// File: rtl/acc_byte_serializer.sv
// acc_byte_serializer
// Buffers accumulator words in a 2-entry FIFO and sends each word to a UART
// transmitter as NB = ceil(WT/8) bytes, least significant byte first.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : acc_byte_serializer_if.slave
//         in_valid/in_data word input, ovf_clr overflow clear,
//         tx_busy/tx_start/tx_byte UART handshake, busy/overflow status
module acc_byte_serializer #(
  parameter int W  = 6,
  parameter int Wc = 4
) (
  input logic                  clk,
  input logic                  rst,
  acc_byte_serializer_if.slave bus
);
  localparam int WT = W * Wc;
  localparam int NB = (WT + 7) / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ACK   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WT-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [IW-1:0] idx;
  logic          tx_start_r;
  logic [7:0]    tx_byte_r;
  logic          overflow_r;
  logic          start_d;
  logic          load_first;
  logic          load_next;
  logic          pop;
  logic          push;
  logic          drop;
  logic          last_byte;
  logic [WT-1:0] head;

  // Byte k of a word, with bits above WT-1 reading as zero.
  function automatic logic [7:0] byte_sel(input logic [WT-1:0] word,
                                          input logic [IW-1:0] k);
    logic [NB*8-1:0] padded;
    padded          = '0;
    padded[WT-1:0]  = word;
    padded          = padded >> {k, 3'b000};
    return padded[7:0];
  endfunction

  assign head      = mem[rd_ptr];
  assign last_byte = (idx == IW'(NB - 1));

  // A full FIFO still accepts a word on the edge that retires the head.
  assign push = bus.in_valid && ((count != 2'd2) || pop);
  assign drop = bus.in_valid && (count == 2'd2) && !pop;

  // State register; tx_start is registered so it only rises once START
  // has been entered and tx_byte is already stable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx_start_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_start_r <= start_d;
    end
  end

  // Next-state logic. START holds until the registered tx_start has pulsed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != 2'd0) state_nxt = START;
      START:   if (tx_start_r)    state_nxt = ACK;
      ACK:     if (bus.tx_busy)   state_nxt = DONE;
      DONE:    if (!bus.tx_busy)  state_nxt = last_byte ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    start_d    = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE:  load_first = (count != 2'd0);
      START: start_d    = !tx_start_r;
      DONE: begin
        load_next = !bus.tx_busy && !last_byte;
        pop       = !bus.tx_busy && last_byte;
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping, byte index, output byte and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      idx        <= '0;
      tx_byte_r  <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      if (load_first) begin
        idx       <= '0;
        tx_byte_r <= byte_sel(head, '0);
      end else if (load_next) begin
        idx       <= IW'(idx + 1'b1);
        tx_byte_r <= byte_sel(head, IW'(idx + 1'b1));
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
      if (drop)             overflow_r <= 1'b1;
      else if (bus.ovf_clr) overflow_r <= 1'b0;
    end
  end

  // Word storage carries no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.tx_start = tx_start_r;
  assign bus.tx_byte  = tx_byte_r;
  assign bus.busy     = (count != 2'd0) || (state != IDLE);
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_acc_byte_serializer.sv
// tb_acc_byte_serializer
// Self-checking bench for acc_byte_serializer at W=6, Wc=4 (24-bit words,
// 3 bytes per word). Includes a UART transmitter model with configurable
// frame length, directed vector table, hand-written corner sequences and a
// randomized run against a word/byte-level reference model.
module tb_acc_byte_serializer;
  localparam int W  = 6;
  localparam int WC = 4;
  localparam int WT = W * WC;
  localparam int NB = (WT + 7) / 8;
  localparam int NV = 6;

  typedef struct {
    logic [WT-1:0] word;
    int            len;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
  } vec_t;

  logic clk;
  logic rst;
  acc_byte_serializer_if #(.W(W), .Wc(WC)) bus ();

  acc_byte_serializer #(.W(W), .Wc(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // UART transmitter model
  int         uart_len = 10;
  int         bcnt = 0;
  int         start_cnt = 0;
  int         proto_err = 0;
  logic [7:0] frame_byte = 8'h00;
  bit         frame_abort = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    if (bus.tx_start === 1'b1) begin
      if (bus.tx_busy === 1'b1) proto_err <= proto_err + 1;
      got_q.push_back(bus.tx_byte);
      start_cnt   <= start_cnt + 1;
      frame_byte  <= bus.tx_byte;
      frame_abort <= 1'b0;
      bcnt        <= uart_len;
      bus.tx_busy <= 1'b1;
    end else begin
      if (rst === 1'b0) frame_abort <= 1'b1;
      else if (bus.tx_busy === 1'b1 && !frame_abort && bus.tx_byte !== frame_byte)
        proto_err <= proto_err + 1;
      if (bcnt > 1) bcnt <= bcnt - 1;
      else begin
        bcnt        <= 0;
        bus.tx_busy <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] byte_of(input logic [WT-1:0] w, input int k);
    logic [WT-1:0] s;
    s = w >> (8 * k);
    return s[7:0];
  endfunction

  task automatic send_word(input logic [WT-1:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (got_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
    check("byte_count", 32'(got_q.size() >= n), 1);
  endtask

  task automatic wait_uart_idle();
    int k = 0;
    while (bus.tx_busy === 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    check("uart_idle", bus.tx_busy, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bus.busy === 1'b1 || bus.tx_busy === 1'b1) && k < 3000) begin
      tick();
      k++;
    end
    check("idle", bus.busy, 0);
  endtask

  // Reference model: FIFO occupancy, accepted words and sticky overflow.
  // A word retires on the first edge that sees tx_busy low after the end
  // of its NB-th frame.
  int            m_cnt;
  int            m_biw;
  bit            m_prev_busy;
  bit            m_ovf;
  logic [WT-1:0] exp_words[$];

  task automatic model_step();
    bit m_pop;
    bit m_push;
    m_pop = 1'b0;
    if (m_prev_busy && bus.tx_busy !== 1'b1) begin
      m_biw++;
      if (m_biw == NB) begin
        m_pop = 1'b1;
        m_biw = 0;
      end
    end
    m_prev_busy = (bus.tx_busy === 1'b1);
    m_push = bus.in_valid && (m_cnt < 2 || m_pop);
    if (m_push) exp_words.push_back(bus.in_data);
    if (bus.in_valid && !m_push) m_ovf = 1'b1;
    else if (bus.ovf_clr)        m_ovf = 1'b0;
    m_cnt = m_cnt + int'(m_push) - int'(m_pop);
  endtask

  vec_t vecs [NV];

  initial begin
    int            s0;
    logic [WT-1:0] wa;
    logic [WT-1:0] wb;
    logic [WT-1:0] wc;
    logic [WT-1:0] w3 [3];

    vecs[0] = '{24'hA5C3F0, 10, 8'hF0, 8'hC3, 8'hA5};
    vecs[1] = '{24'h000001,  1, 8'h01, 8'h00, 8'h00};
    vecs[2] = '{24'hFFFFFF,  3, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{24'h123456,  2, 8'h56, 8'h34, 8'h12};
    vecs[4] = '{24'h800000,  5, 8'h00, 8'h00, 8'h80};
    vecs[5] = '{24'h00FF00,  4, 8'h00, 8'hFF, 8'h00};

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ovf_clr  = 1'b0;
    repeat (3) tick();
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_byte",  bus.tx_byte,  0);
    check("rst_busy",     bus.busy,     0);
    check("rst_overflow", bus.overflow, 0);
    rst = 1'b1;
    tick();

    // Directed words from idle: latency, byte order, pulse count, busy fall.
    for (int v = 0; v < NV; v++) begin
      uart_len = vecs[v].len;
      got_q.delete();
      s0 = start_cnt;
      send_word(vecs[v].word);
      check("lat_edge0", bus.tx_start, 0);
      tick();
      check("lat_edge1", bus.tx_start, 0);
      tick();
      check("lat_start", bus.tx_start, 1);
      check("lat_byte",  bus.tx_byte,  vecs[v].b0);
      wait_bytes(3);
      check("vec_b0", got_at(0), vecs[v].b0);
      check("vec_b1", got_at(1), vecs[v].b1);
      check("vec_b2", got_at(2), vecs[v].b2);
      wait_uart_idle();
      check("busy_hold", bus.busy, 1);
      tick();
      check("busy_fall", bus.busy, 0);
      check("start_pulses", start_cnt - s0, 3);
      check("vec_overflow", bus.overflow, 0);
    end

    // Three consecutive words while the first byte is pending.
    uart_len = 10;
    got_q.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h111111;
    tick();
    check("ovf_w1", bus.overflow, 0);
    bus.in_data = 24'h222222;
    tick();
    check("ovf_w2", bus.overflow, 0);
    bus.in_data = 24'h333333;
    tick();
    bus.in_valid = 1'b0;
    check("ovf_w3", bus.overflow, 1);
    wait_bytes(6);
    wait_idle();
    check("ovf_len", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("ovf_stream", got_at(i), (i < 3) ? 8'h11 : 8'h22);
    check("ovf_sticky", bus.overflow, 1);

    // Overflow clear without a drop, then clear on a drop edge.
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("clr_plain", bus.overflow, 0);
    got_q.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h444444;
    tick();
    bus.in_data = 24'h555555;
    tick();
    bus.in_data = 24'h666666;
    bus.ovf_clr = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    check("clr_on_drop", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("clr_again", bus.overflow, 0);
    wait_bytes(6);
    wait_idle();
    check("clr_len", got_q.size(), 6);
    check("clr_last", got_at(5), 8'h55);

    // Push on the same edge that retires the head while the FIFO is full.
    uart_len = 4;
    got_q.delete();
    wa = 24'h0C0B0A;
    wb = 24'h1D1E1F;
    wc = 24'h2A2B2C;
    send_word(wa);
    send_word(wb);
    wait_bytes(3);
    wait_uart_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = wc;
    tick();
    bus.in_valid = 1'b0;
    check("pp_overflow", bus.overflow, 0);
    check("pp_busy",     bus.busy,     1);
    check("pp_start0",   bus.tx_start, 0);
    tick();
    check("pp_start1",   bus.tx_start, 0);
    tick();
    check("pp_start2",   bus.tx_start, 1);
    check("pp_byte",     bus.tx_byte,  byte_of(wb, 0));
    wait_bytes(9);
    wait_idle();
    w3[0] = wa;
    w3[1] = wb;
    w3[2] = wc;
    check("pp_len", got_q.size(), 9);
    for (int i = 0; i < 9; i++)
      check("pp_stream", got_at(i), byte_of(w3[i / 3], i % 3));
    check("pp_overflow_end", bus.overflow, 0);

    // Reset while waiting for the UART on byte 1; in_valid on the reset edge.
    uart_len = 6;
    got_q.delete();
    send_word(24'hABCDEF);
    wait_bytes(2);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h777777;
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    check("mid_rst_tx_start", bus.tx_start, 0);
    check("mid_rst_tx_byte",  bus.tx_byte,  0);
    check("mid_rst_busy",     bus.busy,     0);
    check("mid_rst_overflow", bus.overflow, 0);
    check("mid_rst_pre0", got_at(0), 8'hEF);
    check("mid_rst_pre1", got_at(1), 8'hCD);
    wait_uart_idle();
    tick();
    tick();
    check("mid_rst_ignored", bus.busy, 0);
    check("mid_rst_nostart", got_q.size(), 2);
    got_q.delete();
    send_word(24'h000001);
    wait_bytes(3);
    check("post_rst_b0", got_at(0), 8'h01);
    check("post_rst_b1", got_at(1), 8'h00);
    check("post_rst_b2", got_at(2), 8'h00);
    wait_idle();

    // Randomized traffic against the reference model.
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("rnd_pre_ovf", bus.overflow, 0);
    uart_len    = $urandom_range(1, 4);
    got_q.delete();
    exp_words.delete();
    m_cnt       = 0;
    m_biw       = 0;
    m_prev_busy = (bus.tx_busy === 1'b1);
    m_ovf       = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom_range(0, 9) == 0);
      bus.in_data  = WT'($urandom);
      bus.ovf_clr  = ($urandom_range(0, 19) == 0);
      model_step();
      tick();
      check("rnd_overflow", bus.overflow, m_ovf);
      check("rnd_busy",     bus.busy,     32'(m_cnt != 0));
    end
    bus.in_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    for (int i = 0; i < 2000 && (m_cnt != 0 || bus.tx_busy === 1'b1); i++) begin
      model_step();
      tick();
      check("rnd_overflow", bus.overflow, m_ovf);
      check("rnd_busy",     bus.busy,     32'(m_cnt != 0));
    end
    check("rnd_drained", bus.busy, 0);
    check("rnd_len", got_q.size(), exp_words.size() * NB);
    for (int i = 0; i < exp_words.size() * NB && i < got_q.size(); i++)
      check("rnd_stream", got_at(i), byte_of(exp_words[i / NB], i % NB));

    check("protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
